// File: rtl/vec_div_q.sv
// vec_div_q: N-lane vector-by-scalar fixed-point divider.
// Radix-2 restoring division, one quotient bit per lane per cycle.
module vec_div_q #(
  parameter int N_LANES = 4,
  parameter int WIDTH   = 32,
  parameter int FRAC    = 16,
  parameter int SIGNED  = 1
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       enable,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [N_LANES*WIDTH-1:0]   vec,
  input  logic [WIDTH-1:0]           el,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [N_LANES*WIDTH-1:0]   res,
  output logic [N_LANES-1:0]         sat,
  output logic                       div_zero
);

  localparam int DW   = WIDTH + FRAC;
  localparam int ITER = DW;
  localparam int CW   = $clog2(ITER + 1);

  localparam logic [CW-1:0]    CNT_INIT = CW'(ITER - 1);
  localparam logic [WIDTH-1:0] MAXP = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0] MINN = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [WIDTH-1:0] ONES = {WIDTH{1'b1}};
  localparam logic [DW-1:0]    MAXP_W = DW'(MAXP);
  localparam logic [DW-1:0]    MINN_W = DW'(MINN);
  localparam logic [DW-1:0]    ONES_W = DW'(ONES);

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    DONE
  } state_e;

  state_e state_q, state_d;

  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] dsr_q, dsr_d;

  // Dividend shifts out MSB-first; quotient bits shift in at the LSB,
  // so after ITER steps this register holds the magnitude quotient.
  logic [N_LANES-1:0][DW-1:0]    dvd_q, dvd_d;
  // Kept remainder is always below the divisor, so WIDTH bits suffice;
  // the trial remainder below is WIDTH+1 bits.
  logic [N_LANES-1:0][WIDTH-1:0] rem_q, rem_d;
  logic [N_LANES-1:0]            neg_q, neg_d;

  logic                     ov_q, ov_d;
  logic [N_LANES*WIDTH-1:0] res_q, res_d;
  logic [N_LANES-1:0]       sat_q, sat_d;
  logic                     dz_q, dz_d;

  logic                          el_neg;
  logic [WIDTH-1:0]              el_mag;
  logic [N_LANES-1:0][WIDTH-1:0] lane_v;
  logic [N_LANES-1:0][WIDTH-1:0] mag_in;
  logic [N_LANES-1:0]            sgn_in;
  logic [N_LANES-1:0][WIDTH:0]   sh;
  logic [N_LANES-1:0]            ge;
  logic [N_LANES-1:0][WIDTH-1:0] dif;
  logic [N_LANES-1:0][WIDTH-1:0] rem_nx;
  logic [N_LANES-1:0][DW-1:0]    dvd_nx;
  logic [N_LANES-1:0][WIDTH-1:0] q_res;
  logic [N_LANES-1:0]            q_sat;
  logic                          dz_now;

  assign in_ready = enable && (state_q == IDLE);
  assign dz_now   = (dsr_q == '0);

  // Operand unpacking, magnitude/sign extraction and one divide step per lane
  always_comb begin
    el_neg = (SIGNED != 0) && el[WIDTH-1];
    el_mag = el_neg ? (WIDTH'(0) - el) : el;
    lane_v = '0;
    mag_in = '0;
    sgn_in = '0;
    sh     = '0;
    ge     = '0;
    dif    = '0;
    rem_nx = '0;
    dvd_nx = '0;
    for (int i = 0; i < N_LANES; i++) begin
      lane_v[i] = vec[N_LANES*WIDTH-1-i*WIDTH -: WIDTH];
      sgn_in[i] = (SIGNED != 0) && lane_v[i][WIDTH-1];
      mag_in[i] = sgn_in[i] ? (WIDTH'(0) - lane_v[i]) : lane_v[i];
      sh[i]     = {rem_q[i], dvd_q[i][DW-1]};
      ge[i]     = (sh[i] >= {1'b0, dsr_q});
      dif[i]    = WIDTH'(sh[i] - {1'b0, dsr_q});
      rem_nx[i] = ge[i] ? dif[i] : sh[i][WIDTH-1:0];
      dvd_nx[i] = {dvd_q[i][DW-2:0], ge[i]};
    end
  end

  // Sign application, saturation and divide-by-zero result per lane
  always_comb begin
    q_res = '0;
    q_sat = '0;
    for (int i = 0; i < N_LANES; i++) begin
      if (dz_now) begin
        if (dvd_q[i] != '0) begin
          q_sat[i] = 1'b1;
          if (SIGNED != 0) begin
            q_res[i] = neg_q[i] ? MINN : MAXP;
          end else begin
            q_res[i] = ONES;
          end
        end
      end else if (SIGNED != 0) begin
        if (!neg_q[i]) begin
          if (dvd_q[i] > MAXP_W) begin
            q_res[i] = MAXP;
            q_sat[i] = 1'b1;
          end else begin
            q_res[i] = dvd_q[i][WIDTH-1:0];
          end
        end else begin
          if (dvd_q[i] > MINN_W) begin
            q_res[i] = MINN;
            q_sat[i] = 1'b1;
          end else begin
            q_res[i] = WIDTH'(0) - dvd_q[i][WIDTH-1:0];
          end
        end
      end else begin
        if (dvd_q[i] > ONES_W) begin
          q_res[i] = ONES;
          q_sat[i] = 1'b1;
        end else begin
          q_res[i] = dvd_q[i][WIDTH-1:0];
        end
      end
    end
  end

  // Next state and next datapath values
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    dsr_d   = dsr_q;
    dvd_d   = dvd_q;
    rem_d   = rem_q;
    neg_d   = neg_q;
    ov_d    = ov_q;
    res_d   = res_q;
    sat_d   = sat_q;
    dz_d    = dz_q;
    unique case (state_q)
      IDLE: begin
        if (in_valid && in_ready) begin
          dsr_d = el_mag;
          cnt_d = CNT_INIT;
          for (int i = 0; i < N_LANES; i++) begin
            dvd_d[i] = DW'(mag_in[i]) << FRAC;
            rem_d[i] = '0;
            neg_d[i] = sgn_in[i] ^ el_neg;
          end
          state_d = (el == '0) ? DONE : CALC;
        end
      end
      CALC: begin
        dvd_d = dvd_nx;
        rem_d = rem_nx;
        if (cnt_q == '0) begin
          state_d = DONE;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      DONE: begin
        if (!ov_q) begin
          ov_d = 1'b1;
          dz_d = dz_now;
          for (int i = 0; i < N_LANES; i++) begin
            res_d[N_LANES*WIDTH-1-i*WIDTH -: WIDTH] = q_res[i];
            sat_d[N_LANES-1-i] = q_sat[i];
          end
        end else if (out_ready) begin
          ov_d    = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State register; enable freezes everything
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
    end else if (enable) begin
      state_q <= state_d;
    end
  end

  // Datapath and output registers; reset abandons any operation
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
      dsr_q <= '0;
      dvd_q <= '0;
      rem_q <= '0;
      neg_q <= '0;
      ov_q  <= 1'b0;
      res_q <= '0;
      sat_q <= '0;
      dz_q  <= 1'b0;
    end else if (enable) begin
      cnt_q <= cnt_d;
      dsr_q <= dsr_d;
      dvd_q <= dvd_d;
      rem_q <= rem_d;
      neg_q <= neg_d;
      ov_q  <= ov_d;
      res_q <= res_d;
      sat_q <= sat_d;
      dz_q  <= dz_d;
    end
  end

  assign out_valid = ov_q;
  assign res       = res_q;
  assign sat       = sat_q;
  assign div_zero  = dz_q;

endmodule

// File: tb/tb_vec_div_q.sv
// tb_vec_div_q: directed bench for vec_div_q (4 lanes, Q16.16, signed).
// Reference model uses plain integer division on 64-bit values.
module tb_vec_div_q;

  logic         clk;
  logic         reset;
  logic         enable;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] vec;
  logic [31:0]  el;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] res;
  logic [3:0]   sat;
  logic         div_zero;

  int n_chk  = 0;
  int n_fail = 0;

  logic         exp_pending = 1'b0;
  logic [127:0] exp_res = '0;
  logic [3:0]   exp_sat = '0;
  logic         exp_dz  = 1'b0;

  vec_div_q #(
    .N_LANES(4),
    .WIDTH  (32),
    .FRAC   (16),
    .SIGNED (1)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .enable   (enable),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .vec      (vec),
    .el       (el),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .res      (res),
    .sat      (sat),
    .div_zero (div_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [127:0] act,
                     input logic [127:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Q16.16 signed quotient from the arithmetic definition
  function automatic void model(input logic [127:0] v,
                                input logic [31:0] e,
                                output logic [127:0] r,
                                output logic [3:0] s,
                                output logic dz);
    longint dv, av, na, nd, q, val;
    r  = '0;
    s  = '0;
    dv = longint'($signed(e));
    dz = (e == 32'h0);
    for (int i = 0; i < 4; i++) begin
      av = longint'($signed(v[127-32*i -: 32]));
      if (dz) begin
        if (av > 0) val = 64'sd1 <<< 40;
        else if (av < 0) val = -(64'sd1 <<< 40);
        else val = 0;
      end else begin
        na  = (av < 0) ? -av : av;
        nd  = (dv < 0) ? -dv : dv;
        q   = (na <<< 16) / nd;
        val = ((av < 0) != (dv < 0)) ? -q : q;
      end
      if (val > 64'sd2147483647) begin
        r[127-32*i -: 32] = 32'h7FFFFFFF;
        s[3-i] = 1'b1;
      end else if (val < -64'sd2147483648) begin
        r[127-32*i -: 32] = 32'h80000000;
        s[3-i] = 1'b1;
      end else begin
        r[127-32*i -: 32] = 32'(val);
      end
    end
  endfunction

  // Compare process: every cycle a result is presented
  always @(negedge clk) begin
    if (!reset && out_valid) begin
      if (!exp_pending) begin
        n_chk++;
        n_fail++;
        $display("FAIL mon_unexpected_valid: got 1 expected 0");
      end else begin
        chk("mon_res", res, exp_res);
        chk("mon_sat", 128'(sat), 128'(exp_sat));
        chk("mon_dz", 128'(div_zero), 128'(exp_dz));
      end
    end
  end

  task automatic run_op(input string nm, input logic [127:0] v,
                        input logic [31:0] e, input logic [127:0] xr,
                        input logic [3:0] xs, input logic xdz,
                        input int xlat, input int st, input int sl,
                        input int hold);
    int n;
    int lat;
    n = 0;
    while (!in_ready && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (!in_ready) begin
      n_chk++;
      n_fail++;
      $display("FAIL %s_ready_timeout: got 0 expected 1", nm);
      return;
    end
    vec      = v;
    el       = e;
    in_valid = 1'b1;
    model(v, e, exp_res, exp_sat, exp_dz);
    exp_pending = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    lat = 0;
    for (int k = 1; k <= 200; k++) begin
      enable = (st == 0) || (k < st) || (k >= st + sl);
      @(posedge clk);
      #1;
      if (out_valid) begin
        lat = k;
        break;
      end
    end
    enable = 1'b1;
    chk({nm, "_latency"}, 128'(lat), 128'(xlat));
    for (int k = 0; k < hold; k++) begin
      in_valid = 1'b1;
      vec      = ~v;
      el       = 32'h0;
      @(posedge clk);
      #1;
      chk({nm, "_hold_in_ready"}, 128'(in_ready), 128'(0));
      chk({nm, "_hold_valid"}, 128'(out_valid), 128'(1));
      chk({nm, "_hold_res"}, res, xr);
    end
    in_valid = 1'b0;
    chk({nm, "_res"}, res, xr);
    chk({nm, "_sat"}, 128'(sat), 128'(xs));
    chk({nm, "_dz"}, 128'(div_zero), 128'(xdz));
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    exp_pending = 1'b0;
    out_ready   = 1'b0;
    chk({nm, "_drain_valid"}, 128'(out_valid), 128'(0));
    chk({nm, "_drain_ready"}, 128'(in_ready), 128'(1));
  endtask

  initial begin
    reset     = 1'b1;
    enable    = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    vec       = '0;
    el        = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid", 128'(out_valid), 128'(0));
    chk("rst_res", res, 128'(0));
    chk("rst_sat", 128'(sat), 128'(0));
    chk("rst_dz", 128'(div_zero), 128'(0));
    chk("rst_ready", 128'(in_ready), 128'(1));
    enable = 1'b0;
    #1;
    chk("rst_ready_dis", 128'(in_ready), 128'(0));
    enable = 1'b1;
    reset  = 1'b0;
    @(posedge clk);
    #1;

    run_op("basic",
           {32'h00060000, 32'hFFFA0000, 32'h00010000, 32'hFFFF0000},
           32'h00020000,
           {32'h00030000, 32'hFFFD0000, 32'h00008000, 32'hFFFF8000},
           4'b0000, 1'b0, 49, 0, 0, 0);

    run_op("trunc",
           {32'h00010000, 32'hFFFF0000, 32'h00000000, 32'h7FFFFFFF},
           32'h00030000,
           {32'h00005555, 32'hFFFFAAAB, 32'h00000000, 32'h2AAAAAAA},
           4'b0000, 1'b0, 49, 0, 0, 0);

    run_op("satur",
           {32'h7FFF0000, 32'h80010000, 32'h00000100, 32'h00000000},
           32'h00000100,
           {32'h7FFFFFFF, 32'h80000000, 32'h00010000, 32'h00000000},
           4'b1100, 1'b0, 49, 0, 0, 5);

    run_op("divzero",
           {32'h00010000, 32'hFFFF0000, 32'h00000000, 32'h00020000},
           32'h00000000,
           {32'h7FFFFFFF, 32'h80000000, 32'h00000000, 32'h7FFFFFFF},
           4'b1101, 1'b1, 1, 0, 0, 0);

    run_op("stall",
           {32'h00030000, 32'hFFFD0000, 32'h80000000, 32'h00000001},
           32'hFFFF0000,
           {32'hFFFD0000, 32'h00030000, 32'h7FFFFFFF, 32'hFFFFFFFF},
           4'b0010, 1'b0, 52, 20, 3, 0);

    run_op("bound",
           {32'h80000000, 32'h7FFFFFFF, 32'hFFFFFFFF, 32'h00000001},
           32'h00010000,
           {32'h80000000, 32'h7FFFFFFF, 32'hFFFFFFFF, 32'h00000001},
           4'b0000, 1'b0, 49, 0, 0, 0);

    vec      = {32'h00060000, 32'h00050000, 32'h00040000, 32'h00030000};
    el       = 32'h00020000;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (20) @(posedge clk);
    #1;
    reset = 1'b1;
    #1;
    chk("midrst_valid", 128'(out_valid), 128'(0));
    chk("midrst_res", res, 128'(0));
    @(posedge clk);
    #1;
    reset = 1'b0;
    chk("postrst_valid", 128'(out_valid), 128'(0));
    chk("postrst_res", res, 128'(0));
    chk("postrst_sat", 128'(sat), 128'(0));
    chk("postrst_dz", 128'(div_zero), 128'(0));
    chk("postrst_ready", 128'(in_ready), 128'(1));

    run_op("after_rst",
           {32'h00010000, 32'hFFFF0000, 32'h00040000, 32'h00000000},
           32'h00040000,
           {32'h00004000, 32'hFFFFC000, 32'h00010000, 32'h00000000},
           4'b0000, 1'b0, 49, 0, 0, 0);

    repeat (3) @(posedge clk);
    #1;
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
